cond_eval_unit: RTL and testbench
=================================

# cond_eval_unit

Multi-channel condition-evaluation unit with an architectural NZCV flag register, a one-deep shadow copy for exception entry/return, registered per-channel results with valid/ready handshake, and per-channel taken counters. It sits between the ALU flag outputs and the branch/predication logic. Each channel evaluates an ARM-style 4-bit condition code against the current flags, so several pipeline slots can resolve conditions in the same cycle.

## Interface
- NUM_CH, 2, number of independent condition-query channels (1..8)
- CNT_W, 16, width of each per-channel taken counter

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flag_we  in  1  write flag_in into the flag register
- flag_in  in  4  new flags {N,Z,C,V}
- flag_save  in  1  copy current flags into shadow register
- flag_restore  in  1  copy shadow register into flag register
- flags  out  4  current flag register {N,Z,C,V}
- q_valid  in  NUM_CH  per-channel query valid
- q_ready  out  NUM_CH  per-channel query accept
- q_code  in  4*NUM_CH  packed condition codes, channel i at [4i+3:4i]
- r_valid  out  NUM_CH  per-channel result valid
- r_ready  in  NUM_CH  per-channel result accept
- r_cond  out  NUM_CH  per-channel condition result
- cnt_clr  in  1  clear all taken counters
- taken_cnt  out  CNT_W*NUM_CH  packed taken counters, channel i at [CNT_W*i+CNT_W-1:CNT_W*i]

## Operation
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Flag register next value, priority high to low: reset -> 0000; flag_restore -> shadow; flag_we -> flag_in; else hold.
- Shadow: reset -> 0000; flag_save -> current flags register (pre-update value, even when flag_we or flag_restore is asserted in the same cycle); else hold.
- Each channel holds a one-entry output register (r_valid, r_cond).
- Handshake per channel: q_ready[i] = !r_valid[i] | r_ready[i]. A query is accepted when q_valid[i] & q_ready[i].
- On acceptance, r_cond[i] <= eval(q_code[i], F) and r_valid[i] <= 1. F is the evaluation flag source (see Configuration).
- When r_valid[i] & r_ready[i] and no new acceptance occurs, r_valid[i] <= 0. r_cond holds its last value.
- Taken counter i increments by 1 when a query is accepted and evaluates true. It saturates at 2^CNT_W-1; no wrap.
- cnt_clr zeroes all counters and has priority over an increment in the same cycle.
- Channels are fully independent. Any combination of channels may be accepted in one cycle.

## Timing
- Reset values: flags=0000, shadow=0000, r_valid=0, r_cond=0, taken_cnt=0. q_ready therefore resets to all 1.
- Query-to-result latency is 1 cycle: accepted at edge k, visible at r_valid/r_cond after edge k.
- Throughput is 1 result per channel per cycle while r_ready is held high.
- Back-pressure: with r_valid=1 and r_ready=0, q_ready=0 and the result is held stable.
- flags output reflects the register and updates the cycle after flag_we or flag_restore.
- Reset mid-operation drops pending results (r_valid=0). No handshake completes in the reset cycle.

## Configuration
- COND_BYPASS_EN defined: F is the flag register's next value. Same-cycle flag_in (under flag_we) or shadow (under flag_restore) is forwarded to queries accepted in that cycle.
- COND_BYPASS_EN undefined: F is the registered flags value. A query in the same cycle as a flag write sees the old flags.

## Test plan
- After reset, flags=0000. Query ch0 code 1 (NE) -> next cycle r_valid[0]=1, r_cond[0]=1, taken_cnt[0]=1.
- flag_we with flag_in=0100 (Z) while ch0 queries code 0 (EQ) in the same cycle -> r_cond=1 with COND_BYPASS_EN, r_cond=0 without. The following EQ query gives 1 in both builds.
- Sweep all 16 codes over all 16 flag values -> r_cond matches the code table. Code F is always 0 and code E always 1.
- flags=1001, flag_save, then flag_we 0010, then flag_restore -> flags reads 1001. Save together with flag_we 0110 -> shadow = pre-update value.
- Hold r_ready[1]=0 after a result -> q_ready[1]=0 and r_cond[1] stable while channel 0 continues at 1 result per cycle. Releasing r_ready[1] restores q_ready[1]=1.
- With CNT_W=4, issue 20 AL queries -> taken_cnt saturates at 15. cnt_clr together with an AL acceptance -> 0.

Source files
------------

// File: rtl/cond_eval_unit_if.sv
// Query/result handshake bundle for cond_eval_unit.
//   q_valid/q_ready/q_code : per-channel condition query (code channel i in q_code[i])
//   r_valid/r_ready/r_cond : per-channel registered result
// master = query issuer / result consumer, slave = cond_eval_unit.
interface cond_eval_unit_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]      q_valid;
  logic [NUM_CH-1:0]      q_ready;
  logic [NUM_CH-1:0][3:0] q_code;
  logic [NUM_CH-1:0]      r_valid;
  logic [NUM_CH-1:0]      r_ready;
  logic [NUM_CH-1:0]      r_cond;

  modport master (output q_valid, q_code, r_ready, input q_ready, r_valid, r_cond);
  modport slave  (input q_valid, q_code, r_ready, output q_ready, r_valid, r_cond);
endinterface

// File: rtl/cond_eval_unit.sv
// Multi-channel ARM-style condition evaluator with NZCV flag register,
// one-deep shadow (save/restore), registered per-channel results and
// saturating per-channel taken counters.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flag_we/flag_in       : write new {N,Z,C,V}
//   flag_save/restore     : flags -> shadow / shadow -> flags
//   flags                 : current flag register
//   bus (slave)           : per-channel query/result handshake
//   cnt_clr               : zero all taken counters
//   taken_cnt[i]          : taken counter for channel i
// Build option: COND_BYPASS_EN forwards the flag register's next value to
// queries accepted in the same cycle; otherwise queries see registered flags.

module cond_eval_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       f,
  input  logic             q_valid,
  input  logic [3:0]       q_code,
  output logic             q_ready,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_cond,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
);
  logic n, z, c, v, hit, acc;

  assign {n, z, c, v} = f;

  always_comb begin
    hit = 1'b0;
    unique case (q_code)
      4'h0: hit = z;
      4'h1: hit = !z;
      4'h2: hit = c;
      4'h3: hit = !c;
      4'h4: hit = n;
      4'h5: hit = !n;
      4'h6: hit = v;
      4'h7: hit = !v;
      4'h8: hit = c & !z;
      4'h9: hit = !c | z;
      4'hA: hit = (n == v);
      4'hB: hit = (n != v);
      4'hC: hit = !z & (n == v);
      4'hD: hit = z | (n != v);
      4'hE: hit = 1'b1;
      4'hF: hit = 1'b0;
      default: hit = 1'b0;
    endcase
  end

  assign q_ready = !r_valid | r_ready;
  assign acc     = q_valid & q_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_cond  <= 1'b0;
    end else if (acc) begin
      r_valid <= 1'b1;
      r_cond  <= hit;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr)
      cnt <= '0;
    else if (acc && hit && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end
endmodule

module cond_eval_unit #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flag_we,
  input  logic [3:0]                   flag_in,
  input  logic                         flag_save,
  input  logic                         flag_restore,
  output logic [3:0]                   flags,
  cond_eval_unit_if.slave              bus,
  input  logic                         cnt_clr,
  output logic [NUM_CH-1:0][CNT_W-1:0] taken_cnt
);
  logic [3:0] shadow, flag_nxt, f_src;

  // restore wins over write
  always_comb begin
    flag_nxt = flags;
    if (flag_restore)  flag_nxt = shadow;
    else if (flag_we)  flag_nxt = flag_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags  <= 4'b0000;
      shadow <= 4'b0000;
    end else begin
      flags <= flag_nxt;
      if (flag_save) shadow <= flags;  // pre-update value
    end
  end

`ifdef COND_BYPASS_EN
  assign f_src = flag_nxt;
`else
  assign f_src = flags;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cond_eval_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .f       (f_src),
      .q_valid (bus.q_valid[i]),
      .q_code  (bus.q_code[i]),
      .q_ready (bus.q_ready[i]),
      .r_valid (bus.r_valid[i]),
      .r_ready (bus.r_ready[i]),
      .r_cond  (bus.r_cond[i]),
      .cnt_clr (cnt_clr),
      .cnt     (taken_cnt[i])
    );
  end
endmodule

// File: tb/tb_cond_eval_unit.sv
module tb_cond_eval_unit;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset, flag_we, flag_save, flag_restore, cnt_clr;
  logic [3:0] flag_in, flags;
  logic [NUM_CH-1:0][CNT_W-1:0] taken_cnt;

  int checks = 0;
  int failures = 0;

  cond_eval_unit_if #(.NUM_CH(NUM_CH)) bus ();

  cond_eval_unit #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flag_we      (flag_we),
    .flag_in      (flag_in),
    .flag_save    (flag_save),
    .flag_restore (flag_restore),
    .flags        (flags),
    .bus          (bus),
    .cnt_clr      (cnt_clr),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // condition table written straight from the code list
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (code)
      4'h0: return z == 1'b1;
      4'h1: return z == 1'b0;
      4'h2: return c == 1'b1;
      4'h3: return c == 1'b0;
      4'h4: return n == 1'b1;
      4'h5: return n == 1'b0;
      4'h6: return v == 1'b1;
      4'h7: return v == 1'b0;
      4'h8: return (c == 1'b1) && (z == 1'b0);
      4'h9: return (c == 1'b0) || (z == 1'b1);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return (z == 1'b0) && (n == v);
      4'hD: return (z == 1'b1) || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    reset = 1'b1; flag_we = 0; flag_in = 0; flag_save = 0; flag_restore = 0; cnt_clr = 0;
    bus.q_valid = '0; bus.q_code = '0; bus.r_ready = 2'b11;
    step(); step();
    reset = 1'b0;

    // reset state
    chk("rst_flags", flags, 4'b0000);
    chk("rst_rvalid", bus.r_valid, 2'b00);
    chk("rst_rcond", bus.r_cond, 2'b00);
    chk("rst_cnt", taken_cnt, 8'h00);
    chk("rst_qready", bus.q_ready, 2'b11);

    // NE with Z=0
    bus.q_valid = 2'b01; bus.q_code[0] = 4'h1;
    step();
    bus.q_valid = 2'b00;
    chk("ne_rvalid", bus.r_valid[0], 1'b1);
    chk("ne_rcond", bus.r_cond[0], 1'b1);
    chk("ne_cnt", taken_cnt[0], 4'd1);

    // EQ in the same cycle as a write of Z
    flag_we = 1; flag_in = 4'b0100;
    bus.q_valid = 2'b01; bus.q_code[0] = 4'h0;
    step();
    flag_we = 0;
`ifdef COND_BYPASS_EN
    chk("byp_eq", bus.r_cond[0], 1'b1);
`else
    chk("byp_eq", bus.r_cond[0], 1'b0);
`endif
    chk("byp_flags", flags, 4'b0100);
    step();
    bus.q_valid = 2'b00;
    chk("byp_eq2", bus.r_cond[0], 1'b1);
`ifdef COND_BYPASS_EN
    chk("byp_cnt", taken_cnt[0], 4'd3);
`else
    chk("byp_cnt", taken_cnt[0], 4'd2);
`endif

    // sweep all codes x all flags; ch1 runs the mirrored code
    for (int fv = 0; fv < 16; fv++) begin
      flag_we = 1; flag_in = 4'(fv);
      step();
      flag_we = 0;
      for (int cd = 0; cd < 16; cd++) begin
        bus.q_valid = 2'b11; bus.q_code[0] = 4'(cd); bus.q_code[1] = 4'(15 - cd);
        step();
        chk($sformatf("sw0_f%0h_c%0h", fv, cd), bus.r_cond[0], ref_cond(4'(cd), 4'(fv)));
        chk($sformatf("sw1_f%0h_c%0h", fv, 15 - cd), bus.r_cond[1], ref_cond(4'(15 - cd), 4'(fv)));
      end
      bus.q_valid = 2'b00;
    end
    // hand-picked: flags 1001 -> GE(A)=1, LT(B)=0, HI(8)=0 handled above; spot GT with N=V, Z=0
    flag_we = 1; flag_in = 4'b1001; step(); flag_we = 0;
    bus.q_valid = 2'b11; bus.q_code[0] = 4'hC; bus.q_code[1] = 4'hD;
    step();
    bus.q_valid = 2'b00;
    chk("spot_gt", bus.r_cond[0], 1'b1);
    chk("spot_le", bus.r_cond[1], 1'b0);

    // save / write / restore (flags currently 1001)
    flag_save = 1; step(); flag_save = 0;
    flag_we = 1; flag_in = 4'b0010; step(); flag_we = 0;
    chk("sv_wr", flags, 4'b0010);
    flag_restore = 1; step(); flag_restore = 0;
    chk("sv_rest", flags, 4'b1001);
    flag_save = 1; flag_we = 1; flag_in = 4'b0110; step(); flag_save = 0; flag_we = 0;
    chk("sv_same_wr", flags, 4'b0110);
    flag_restore = 1; flag_we = 1; flag_in = 4'b1111; step(); flag_restore = 0; flag_we = 0;
    chk("sv_pre_upd", flags, 4'b1001);

    // back-pressure on ch1, ch0 keeps streaming
    bus.r_ready = 2'b01;
    bus.q_valid = 2'b11; bus.q_code[1] = 4'hE; bus.q_code[0] = 4'hE;
    step();
    chk("bp_rv1", bus.r_valid[1], 1'b1);
    chk("bp_rc1", bus.r_cond[1], 1'b1);
    chk("bp_qr1", bus.q_ready[1], 1'b0);
    chk("bp_rc0a", bus.r_cond[0], 1'b1);
    bus.q_code[1] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus.q_code[0] = (k % 2 == 0) ? 4'hF : 4'hE;
      step();
      chk($sformatf("bp_hold_rc1_%0d", k), bus.r_cond[1], 1'b1);
      chk($sformatf("bp_hold_qr1_%0d", k), bus.q_ready[1], 1'b0);
      chk($sformatf("bp_rv0_%0d", k), bus.r_valid[0], 1'b1);
      chk($sformatf("bp_rc0_%0d", k), bus.r_cond[0], (k % 2 == 0) ? 1'b0 : 1'b1);
    end
    bus.r_ready = 2'b11;
    #1;
    chk("bp_release_qr", bus.q_ready, 2'b11);
    step();
    chk("bp_new_rc1", bus.r_cond[1], 1'b0);
    bus.q_valid = 2'b00;
    step();
    chk("bp_drain", bus.r_valid, 2'b00);

    // counter saturation
    cnt_clr = 1; step(); cnt_clr = 0;
    chk("cnt_clr", taken_cnt, 8'h00);
    bus.q_valid = 2'b01; bus.q_code[0] = 4'hE;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 13) chk("cnt_14", taken_cnt[0], 4'd14);
    end
    chk("cnt_sat", taken_cnt[0], 4'd15);
    chk("cnt_ch1", taken_cnt[1], 4'd0);
    cnt_clr = 1; step(); cnt_clr = 0;
    chk("cnt_clr_pri", taken_cnt[0], 4'd0);
    step();
    chk("cnt_after_clr", taken_cnt[0], 4'd1);

    // reset mid-operation drops pending results
    bus.q_valid = 2'b11; bus.r_ready = 2'b00;
    step();
    chk("mid_rv", bus.r_valid, 2'b11);
    reset = 1; step(); reset = 0;
    bus.q_valid = 2'b00;
    chk("mid_rst_rv", bus.r_valid, 2'b00);
    chk("mid_rst_cnt", taken_cnt, 8'h00);
    chk("mid_rst_flags", flags, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
